// File: rtl/cpu_ctrl_gen2_if.sv
// Bus between the cpu_ctrl_gen2 control unit and the instruction memory, data memory,
// register file and ALU of the simple CPU core.
interface cpu_ctrl_gen2_if #(
  parameter int unsigned PC_W = 16,
  parameter int unsigned DA_W = 8,
  parameter int unsigned RA_W = 4
);
  logic [15:0]     inst;
  logic [PC_W-1:0] progcntr;
  logic            fetch;
  logic [DA_W-1:0] D_addr;
  logic            D_rd;
  logic            D_wr;
  logic            D_ready;
  logic [7:0]      RF_W_data;
  logic            RF_s1;
  logic            RF_s0;
  logic [RA_W-1:0] RF_W_addr;
  logic            RF_W_wr;
  logic [RA_W-1:0] RF_Rp_addr;
  logic [RA_W-1:0] RF_Rq_addr;
  logic            RF_Rp_rd;
  logic            RF_Rq_rd;
  logic            RF_Rp_zero;
  logic            alu_s1;
  logic            alu_s0;
  logic            halted;
  logic [1:0]      trap;

  modport master (
    input  inst, D_ready, RF_Rp_zero,
    output progcntr, fetch, D_addr, D_rd, D_wr, RF_W_data, RF_s1, RF_s0, RF_W_addr, RF_W_wr,
           RF_Rp_addr, RF_Rq_addr, RF_Rp_rd, RF_Rq_rd, alu_s1, alu_s0, halted, trap
  );

  modport slave (
    output inst, D_ready, RF_Rp_zero,
    input  progcntr, fetch, D_addr, D_rd, D_wr, RF_W_data, RF_s1, RF_s0, RF_W_addr, RF_W_wr,
           RF_Rp_addr, RF_Rq_addr, RF_Rp_rd, RF_Rq_rd, alu_s1, alu_s0, halted, trap
  );
endinterface

// File: rtl/cpu_ctrl_gen2.sv
// Second-generation control unit: fetch/decode/sequence of the 16-bit instruction set,
// with a data-memory ready handshake, timeout and HALT/illegal-opcode trapping.
module cpu_ctrl_gen2 #(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned DA_W     = 8,
  parameter int unsigned RA_W     = 4,
  parameter int unsigned WAIT_MAX = 15
) (
  input logic             clk,
  input logic             rst,
  cpu_ctrl_gen2_if.master bus
);

  localparam int unsigned WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WaitLast = WW'(WAIT_MAX - 1);

  localparam logic [3:0] OpLoad  = 4'h0;
  localparam logic [3:0] OpStore = 4'h1;
  localparam logic [3:0] OpAdd   = 4'h2;
  localparam logic [3:0] OpLdc   = 4'h3;
  localparam logic [3:0] OpSub   = 4'h4;
  localparam logic [3:0] OpJmpz  = 4'h5;
  localparam logic [3:0] OpNop   = 4'he;
  localparam logic [3:0] OpHalt  = 4'hf;

  typedef enum logic [3:0] {
    StInit, StFetch, StDecode, StLoad, StStore, StAlu, StLdc, StJmpz, StStop
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [1:0]      trap_q, trap_d;

  logic [3:0]      opcode;
  logic [RA_W-1:0] ra, rb, rc;
  logic [PC_W-1:0] off_sext;

  assign opcode   = ir_q[15:12];
  assign ra       = RA_W'(ir_q[11:8]);
  assign rb       = RA_W'(ir_q[7:4]);
  assign rc       = RA_W'(ir_q[3:0]);
  assign off_sext = PC_W'($signed(ir_q[7:0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      pc_q    <= '0;
      ir_q    <= '0;
      wait_q  <= '0;
      trap_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    trap_d  = trap_q;

    bus.progcntr   = pc_q;
    bus.fetch      = 1'b0;
    bus.D_addr     = '0;
    bus.D_rd       = 1'b0;
    bus.D_wr       = 1'b0;
    bus.RF_W_data  = '0;
    bus.RF_s1      = 1'b0;
    bus.RF_s0      = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_W_wr    = 1'b0;
    bus.RF_Rp_addr = '0;
    bus.RF_Rq_addr = '0;
    bus.RF_Rp_rd   = 1'b0;
    bus.RF_Rq_rd   = 1'b0;
    bus.alu_s1     = 1'b0;
    bus.alu_s0     = 1'b0;
    bus.halted     = 1'b0;
    bus.trap       = trap_q;

    unique case (state_q)
      StInit: state_d = StFetch;
      StFetch: begin
        bus.fetch = 1'b1;
        ir_d      = bus.inst;
        pc_d      = pc_q + PC_W'(1);
        state_d   = StDecode;
      end
      StDecode: begin
        case (opcode)
          OpLoad:  begin state_d = StLoad;  wait_d = '0; end
          OpStore: begin state_d = StStore; wait_d = '0; end
          OpAdd, OpSub: state_d = StAlu;
          OpLdc:   state_d = StLdc;
          OpJmpz:  state_d = StJmpz;
          OpNop:   state_d = StFetch;
          OpHalt:  begin state_d = StStop; trap_d = 2'b01; end
          default: begin state_d = StStop; trap_d = 2'b10; end
        endcase
      end
      StLoad, StStore: begin
        bus.D_addr = DA_W'(ir_q[7:0]);
        if (state_q == StLoad) begin
          bus.D_rd      = 1'b1;
          bus.RF_s0     = 1'b1;
          bus.RF_W_addr = ra;
          bus.RF_W_wr   = bus.D_ready;
        end else begin
          bus.D_wr       = 1'b1;
          bus.RF_Rp_addr = ra;
          bus.RF_Rp_rd   = 1'b1;
        end
        if (bus.D_ready) begin
          state_d = StFetch;
        end else if (wait_q == WaitLast) begin
          state_d = StStop;
          trap_d  = 2'b11;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      StAlu: begin
        bus.RF_Rp_addr = rb;
        bus.RF_Rq_addr = rc;
        bus.RF_Rp_rd   = 1'b1;
        bus.RF_Rq_rd   = 1'b1;
        bus.alu_s0     = (opcode == OpAdd);
        bus.alu_s1     = (opcode == OpSub);
        bus.RF_W_addr  = ra;
        bus.RF_W_wr    = 1'b1;
        state_d        = StFetch;
      end
      StLdc: begin
        bus.RF_s1     = 1'b1;
        bus.RF_W_data = ir_q[7:0];
        bus.RF_W_addr = ra;
        bus.RF_W_wr   = 1'b1;
        state_d       = StFetch;
      end
      StJmpz: begin
        bus.RF_Rp_addr = ra;
        bus.RF_Rp_rd   = 1'b1;
        // pc_q already points past the JMPZ, so step back one before adding the offset.
        if (bus.RF_Rp_zero) pc_d = pc_q - PC_W'(1) + off_sext;
        state_d = StFetch;
      end
      StStop: bus.halted = 1'b1;
      default: state_d = StInit;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_gen2.sv
// Directed bench for cpu_ctrl_gen2: small programs in a behavioural instruction memory,
// with hand-computed expectations for strobes, PC and trap codes.
module tb_cpu_ctrl_gen2;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_ready;
  logic        rp_zero;
  logic [15:0] imem [256];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  cpu_ctrl_gen2_if #(.PC_W(16), .DA_W(8), .RA_W(4)) bus ();

  assign bus.inst       = imem[bus.progcntr[7:0]];
  assign bus.D_ready    = d_ready;
  assign bus.RF_Rp_zero = rp_zero;

  cpu_ctrl_gen2 #(.PC_W(16), .DA_W(8), .RA_W(4), .WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  // Holds reset over two edges and releases 1 time unit after an edge (state INIT).
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [5:0] strobes();
    return {bus.fetch, bus.D_rd, bus.D_wr, bus.RF_W_wr, bus.RF_Rp_rd, bus.RF_Rq_rd};
  endfunction

  task automatic run_to_halt(input string tag);
    int n;
    n = 0;
    while (!bus.halted && n < 100) begin
      tick();
      n++;
    end
    check_val({tag, "_halt_reached"}, 32'(bus.halted), 32'd1);
  endtask

  // Runs until the first fetch after a JMPZ executes; returns that fetch address.
  task automatic jmpz_target(output logic [15:0] pc);
    logic seen;
    int   n;
    seen = 1'b0;
    pc   = 16'hdead;
    n    = 0;
    while (n < 100) begin
      if (bus.RF_Rp_rd && !bus.D_wr) seen = 1'b1;
      if (seen && bus.fetch) begin
        pc = bus.progcntr;
        break;
      end
      tick();
      n++;
    end
  endtask

  initial begin
    int          nw, cnt;
    logic [3:0]  waddr [3];
    logic [1:0]  alus  [3];
    logic [7:0]  wdata0;
    logic        wr_seen;
    logic [15:0] pc;

    d_ready = 1'b1;
    rp_zero = 1'b0;
    rst     = 1'b1;

    // Program 1: LDC R1,#5; LDC R2,#3; ADD R3,R1,R2; HALT
    clear_prog();
    imem[0] = 16'h3105;
    imem[1] = 16'h3203;
    imem[2] = 16'h2312;
    imem[3] = 16'hF000;
    #3;
    check_val("rst_strobes", 32'(strobes()), 32'd0);
    check_val("rst_pc", 32'(bus.progcntr), 32'd0);
    check_val("rst_status", 32'({bus.halted, bus.trap}), 32'd0);
    check_val("rst_daddr", 32'(bus.D_addr), 32'd0);
    do_reset();
    tick();
    check_val("first_fetch", 32'({bus.fetch, bus.progcntr}), 32'h1_0000);
    nw = 0;
    wdata0 = '0;
    for (int i = 0; i < 60 && !bus.halted; i++) begin
      if (bus.RF_W_wr) begin
        if (nw < 3) begin
          waddr[nw] = bus.RF_W_addr;
          alus[nw]  = {bus.alu_s1, bus.alu_s0};
          if (nw == 0) wdata0 = bus.RF_W_data;
        end
        nw++;
      end
      tick();
    end
    check_val("p1_nwrites", 32'(nw), 32'd3);
    check_val("p1_waddr0", 32'(waddr[0]), 32'd1);
    check_val("p1_waddr1", 32'(waddr[1]), 32'd2);
    check_val("p1_waddr2", 32'(waddr[2]), 32'd3);
    check_val("p1_alu_add", 32'(alus[2]), 32'b01);
    check_val("p1_ldc_data", 32'(wdata0), 32'd5);
    check_val("p1_halted", 32'({bus.halted, bus.trap}), 32'b101);
    check_val("p1_pc", 32'(bus.progcntr), 32'd4);
    repeat (3) tick();
    check_val("p1_pc_frozen", 32'(bus.progcntr), 32'd4);
    check_val("p1_stop_strobes", 32'(strobes()), 32'd0);

    // STORE 0x20,R3 with D_ready on the fourth STORE cycle
    clear_prog();
    imem[0] = 16'h1320;
    d_ready = 1'b0;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 10 && !bus.D_wr; i++) tick();
    check_val("st_addr", 32'({bus.D_addr, bus.RF_Rp_addr, bus.RF_Rp_rd}), 32'({8'h20, 4'd3, 1'b1}));
    while (bus.D_wr && cnt < 20) begin
      cnt++;
      if (bus.D_addr !== 8'h20) check_val("st_addr_stable", 32'(bus.D_addr), 32'h20);
      if (cnt == 4) d_ready = 1'b1;
      tick();
      d_ready = 1'b0;
    end
    check_val("st_cycles", 32'(cnt), 32'd4);
    check_val("st_then_fetch", 32'({bus.fetch, bus.progcntr}), 32'h1_0001);

    // LOAD R4,0x10 with no D_ready: timeout
    clear_prog();
    imem[0] = 16'h0410;
    d_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && !bus.D_rd; i++) tick();
    check_val("ld_decode", 32'({bus.D_addr, bus.RF_W_addr, bus.RF_s1, bus.RF_s0}),
              32'({8'h10, 4'd4, 2'b01}));
    cnt     = 0;
    wr_seen = 1'b0;
    while (bus.D_rd && cnt < 40) begin
      cnt++;
      if (bus.RF_W_wr) wr_seen = 1'b1;
      tick();
    end
    check_val("ld_wait_cycles", 32'(cnt), 32'd15);
    check_val("ld_timeout_trap", 32'({bus.halted, bus.trap}), 32'b111);
    check_val("ld_no_write", 32'(wr_seen), 32'd0);

    // NOPs up to address 5, JMPZ R0,-2 at address 6
    clear_prog();
    for (int i = 0; i < 6; i++) imem[i] = 16'hE000;
    imem[6] = 16'h50FE;
    rp_zero = 1'b1;
    do_reset();
    tick();
    tick();
    check_val("nop_decode_quiet", 32'({strobes(), bus.progcntr}), 32'({6'd0, 16'd1}));
    tick();
    check_val("nop_next_fetch", 32'({bus.fetch, bus.progcntr}), 32'h1_0001);
    jmpz_target(pc);
    check_val("jmpz_taken", 32'(pc), 32'd4);
    rp_zero = 1'b0;
    do_reset();
    jmpz_target(pc);
    check_val("jmpz_not_taken", 32'(pc), 32'd7);

    // JMPZ at 0 with offset -1 wraps to the top of the PC space
    clear_prog();
    imem[0] = 16'h50FF;
    rp_zero = 1'b1;
    do_reset();
    jmpz_target(pc);
    check_val("jmpz_wrap", 32'(pc), 32'hFFFF);

    // Illegal opcode 0x7
    clear_prog();
    imem[0] = 16'h7123;
    do_reset();
    run_to_halt("illegal");
    check_val("illegal_trap", 32'(bus.trap), 32'b10);

    // Reset during a LOAD wait
    clear_prog();
    imem[0] = 16'h0410;
    d_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && !bus.D_rd; i++) tick();
    repeat (3) tick();
    check_val("rstmid_in_load", 32'(bus.D_rd), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("rstmid_strobes", 32'(strobes()), 32'd0);
    check_val("rstmid_regs", 32'({bus.halted, bus.trap, bus.progcntr, bus.D_addr}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_val("rstmid_restart", 32'({bus.fetch, bus.progcntr}), 32'h1_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
